// File: rtl/sub_pkg.sv
// Shared types and constants for the multi-word sequential subtractor.
package sub_pkg;

   // Operation sequencing: wait for operands, walk the limbs, hold the result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Result handling on underflow.
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/limb_sub.sv
// One LIMB-bit slice of the subtract: diff = a - b - bin, bout = 1 on underflow.
module limb_sub
   import sub_pkg::*;
#(
   parameter int LIMB = 8
) (
   input  logic [LIMB-1:0] a,
   input  logic [LIMB-1:0] b,
   input  logic            bin,
   output logic [LIMB-1:0] diff,
   output logic            bout
);

   logic [LIMB:0] ext;

   // Widen by one bit; the extra bit goes high exactly when the slice result is negative.
   always_comb begin
      ext  = {1'b0, a} - {1'b0, b} - {{LIMB{1'b0}}, bin};
      diff = ext[LIMB-1:0];
      bout = ext[LIMB];
   end

endmodule

// File: rtl/multiword_subtractor_seq.sv
// Sequential WIDTH-bit subtractor: one LIMB-bit slice per cycle, LSB limb first,
// borrow chained between slices, with wrap-around or unsigned-saturating result.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
// Input side: in_ready is 1 only in IDLE; a, b and mode are captured on that edge.
// Output side: out_valid is 1 only in DONE; diff/borrow/zero are held until the edge
// where out_ready is also 1. Neither ready depends combinationally on valid.
module multiword_subtractor_seq
   import sub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int LIMB  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             zero
);

   localparam int NLIMBS = WIDTH / LIMB;
   localparam int IDXW   = (NLIMBS > 1) ? $clog2(NLIMBS) : 1;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   idx_q;
   logic              chain_q;
   logic [WIDTH-1:0]  a_q, b_q;
   logic              mode_q;
   logic [WIDTH-1:0]  diff_q;
   logic              borrow_q;
   logic              zero_q;

   logic [LIMB-1:0]   limb_a, limb_b, limb_d;
   logic              limb_bout;
   logic              last;
   logic [WIDTH-1:0]  diff_upd;

   // Select the current slice of the latched operands.
   always_comb begin
      limb_a = a_q[idx_q*LIMB +: LIMB];
      limb_b = b_q[idx_q*LIMB +: LIMB];
      last   = (idx_q == IDXW'(NLIMBS - 1));
   end

   limb_sub #(.LIMB(LIMB)) u_limb (
      .a    (limb_a),
      .b    (limb_b),
      .bin  (chain_q),
      .diff (limb_d),
      .bout (limb_bout)
   );

   // Merge this cycle's slice into the result; on the final slice apply saturation.
   always_comb begin
      diff_upd = diff_q;
      diff_upd[idx_q*LIMB +: LIMB] = limb_d;
      if (last && (mode_q == MODE_SAT) && limb_bout) begin
         diff_upd = '0;
      end
   end

   // Next-state logic for the operation sequencer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = RUN;
         RUN:     if (last) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register; reset discards any in-flight operation.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Operand capture, limb walk and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q    <= '0;
         chain_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         mode_q   <= MODE_WRAP;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b;
                  mode_q  <= mode;
                  chain_q <= 1'b0;
                  idx_q   <= '0;
               end
            end
            RUN: begin
               diff_q  <= diff_upd;
               chain_q <= limb_bout;
               if (last) begin
                  idx_q    <= '0;
                  borrow_q <= limb_bout;
                  zero_q   <= (diff_upd == '0);
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs come straight from registers or a decode of the state register.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      diff      = diff_q;
      borrow    = borrow_q;
      zero      = zero_q;
   end

endmodule

// File: tb/tb_multiword_subtractor_seq.sv
// Directed bench for multiword_subtractor_seq with WIDTH=32, LIMB=8.
module tb_multiword_subtractor_seq;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        mode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] diff;
   logic        borrow;
   logic        zero;

   int n_cmp;
   int n_err;

   multiword_subtractor_seq #(.WIDTH(32), .LIMB(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow),
      .zero      (zero)
   );

   // Clock and reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Present one operation at the current (post-edge) time and wait for its result.
   // Returns with the DUT in DONE and out_ready still low.
   task automatic issue(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic mv);
      int lat;
      lat = 0;
      chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      a        = av;
      b        = bv;
      mode     = mv;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      // Operands must be ignored once captured.
      a    = $urandom;
      b    = $urandom;
      mode = ~mv;
      chk({tag, ".busy"}, {31'd0, in_ready}, 32'd0);
      while (lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         if (out_valid === 1'b1) break;
      end
      chk({tag, ".latency"}, lat, 32'd4);
   endtask

   task automatic check_result(input string tag, input logic [31:0] ed, input logic eb,
                               input logic ez);
      chk({tag, ".diff"},   diff, ed);
      chk({tag, ".borrow"}, {31'd0, borrow}, {31'd0, eb});
      chk({tag, ".zero"},   {31'd0, zero},   {31'd0, ez});
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, ".out_valid_fall"}, {31'd0, out_valid}, 32'd0);
      chk({tag, ".in_ready_rise"},  {31'd0, in_ready},  32'd1);
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = 32'h0;
      b         = 32'h0;
      mode      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.in_ready",  {31'd0, in_ready},  32'd1);
      chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset.diff",      diff, 32'h0);
      chk("reset.borrow",    {31'd0, borrow}, 32'd0);
      chk("reset.zero",      {31'd0, zero},   32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 1: simple wrap subtract
      issue("t1", 32'h00000012, 32'h00000005, 1'b0);
      check_result("t1", 32'h0000000D, 1'b0, 1'b0);
      drain("t1");

      // 2: borrow ripples through every limb
      issue("t2", 32'h00000000, 32'h00000001, 1'b0);
      check_result("t2", 32'hFFFFFFFF, 1'b1, 1'b0);
      drain("t2");

      // 3: same underflow, saturating
      issue("t3", 32'h00000000, 32'h00000001, 1'b1);
      check_result("t3", 32'h00000000, 1'b1, 1'b1);
      drain("t3");

      // 4: equal operands, then a small positive difference
      issue("t4a", 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
      check_result("t4a", 32'h00000000, 1'b0, 1'b1);
      drain("t4a");
      issue("t4b", 32'h000000FF, 32'h000000FE, 1'b1);
      check_result("t4b", 32'h00000001, 1'b0, 1'b0);
      drain("t4b");

      // 5: backpressure in DONE, then back-to-back issue
      issue("t5a", 32'h80000000, 32'h00000001, 1'b0);
      check_result("t5a", 32'h7FFFFFFF, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("t5.hold.out_valid", {31'd0, out_valid}, 32'd1);
         chk("t5.hold.in_ready",  {31'd0, in_ready},  32'd0);
         chk("t5.hold.diff",      diff, 32'h7FFFFFFF);
         chk("t5.hold.borrow",    {31'd0, borrow}, 32'd0);
      end
      drain("t5a");
      issue("t5b", 32'h00000100, 32'h00000001, 1'b0);
      check_result("t5b", 32'h000000FF, 1'b0, 1'b0);
      drain("t5b");

      // 6: reset during the second RUN cycle discards the operation
      in_valid = 1'b1;
      a        = 32'h12345678;
      b        = 32'h00000001;
      mode     = 1'b0;
      @(posedge clk);          // acceptance
      #1;
      in_valid = 1'b0;
      @(posedge clk);          // first RUN cycle
      #1;
      rst = 1'b1;
      @(posedge clk);          // second RUN cycle edge, under reset
      #1;
      rst = 1'b0;
      chk("t6.out_valid", {31'd0, out_valid}, 32'd0);
      chk("t6.in_ready",  {31'd0, in_ready},  32'd1);
      chk("t6.diff",      diff, 32'h0);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         chk("t6.no_result", {31'd0, out_valid}, 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
